axi_rd_arbiter: RTL and testbench

- Two-requester read-channel arbiter sharing the single 128-bit AXI-style memory read port between the instruction cache (m0) and the data cache (m1).
- Holds one outstanding read at a time, which the memory model supports.
- Blocks new reads while a write is in flight.
- Grants fairly by round-robin.
- Converts a stalled memory read into an error response after a timeout.

---
 rtl/axi_rd_arbiter.sv | 132 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter putting the icache (m0) and dcache (m1) reads onto one memory read port.
// One read is outstanding at a time. Reads wait while a write is busy. A stalled read ends in an error response.
module axi_rd_arbiter #(
   parameter int ADDR_W         = 64,
   parameter int DATA_W         = 128,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [1:0]          m_readAddr_valid,
   output logic [1:0]          m_readAddr_ready,
   input  logic [2*ADDR_W-1:0] m_readAddr_bits_addr,
   output logic [1:0]          m_readData_valid,
   input  logic [1:0]          m_readData_ready,
   output logic [DATA_W-1:0]   m_readData_bits_data,
   output logic [1:0]          m_readData_bits_resp,
   output logic                s_readAddr_valid,
   input  logic                s_readAddr_ready,
   output logic [ADDR_W-1:0]   s_readAddr_bits_addr,
   output logic [2:0]          s_readAddr_bits_prot,
   input  logic                s_readData_valid,
   output logic                s_readData_ready,
   input  logic [DATA_W-1:0]   s_readData_bits_data,
   input  logic [1:0]          s_readData_bits_resp,
   input  logic                wr_busy,
   output logic                err_timeout
);
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, ERR = 2'd3} state_t;

   state_t              state_reg, state_next;
   logic                grant, prio, err_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [TW-1:0]       tcnt;

   logic                winner, accept, data_hs, err_hs, timeout;
   logic [ADDR_W-1:0]   winner_addr;

   // The preferred requester wins when it asks; otherwise the only asking one wins.
   assign winner      = m_readAddr_valid[prio] ? prio : ~prio;
   assign winner_addr = winner ? m_readAddr_bits_addr[2*ADDR_W-1:ADDR_W]
                               : m_readAddr_bits_addr[ADDR_W-1:0];
   assign accept      = rst && (state_reg == IDLE) && !wr_busy && (|m_readAddr_valid);
   assign data_hs     = (state_reg == DATA) && s_readData_valid && m_readData_ready[grant];
   assign err_hs      = (state_reg == ERR) && m_readData_ready[grant];
   // A handshake that lands on the last allowed cycle still completes normally.
   assign timeout     = (tcnt >= TLAST) &&
                        (((state_reg == ADDR) && !s_readAddr_ready) ||
                         ((state_reg == DATA) && !data_hs));
   assign err_timeout = err_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grant  <= 1'b0;
         prio   <= 1'b0;
         addr_q <= '0;
         tcnt   <= '0;
         err_q  <= 1'b0;
      end else begin
         if (accept) begin
            grant  <= winner;
            addr_q <= winner_addr;
            tcnt   <= '0;
         end else if ((state_reg == ADDR) || (state_reg == DATA)) begin
            tcnt <= tcnt + TW'(1);
         end
         if (timeout) begin
            err_q <= 1'b1;
         end
         if (data_hs || err_hs) begin
            prio <= ~grant;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (accept) state_next = ADDR;
         ADDR: begin
            if (timeout)               state_next = ERR;
            else if (s_readAddr_ready) state_next = DATA;
         end
         DATA: begin
            if (timeout)      state_next = ERR;
            else if (data_hs) state_next = IDLE;
         end
         ERR:  if (err_hs) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      m_readAddr_ready     = 2'b00;
      m_readData_valid     = 2'b00;
      m_readData_bits_data = '0;
      m_readData_bits_resp = 2'b00;
      s_readAddr_valid     = 1'b0;
      s_readAddr_bits_addr = '0;
      s_readAddr_bits_prot = 3'b000;
      s_readData_ready     = 1'b0;
      case (state_reg)
         IDLE: if (accept) m_readAddr_ready[winner] = 1'b1;
         ADDR: begin
            s_readAddr_valid     = 1'b1;
            s_readAddr_bits_addr = addr_q;
            s_readAddr_bits_prot = {~grant, 2'b00};
         end
         DATA: begin
            s_readData_ready        = m_readData_ready[grant];
            m_readData_valid[grant] = s_readData_valid;
            m_readData_bits_data    = s_readData_bits_data;
            m_readData_bits_resp    = s_readData_bits_resp;
         end
         ERR: begin
            m_readData_valid[grant] = 1'b1;
            m_readData_bits_resp    = 2'b10;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus a randomized run checked against a transaction-level model.
module tb_axi_rd_arbiter;
   localparam int AW = 64;
   localparam int DW = 128;
   localparam int TO = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      m_readAddr_valid, m_readAddr_ready;
   logic [2*AW-1:0] m_readAddr_bits_addr;
   logic [1:0]      m_readData_valid, m_readData_ready;
   logic [DW-1:0]   m_readData_bits_data;
   logic [1:0]      m_readData_bits_resp;
   logic            s_readAddr_valid, s_readAddr_ready;
   logic [AW-1:0]   s_readAddr_bits_addr;
   logic [2:0]      s_readAddr_bits_prot;
   logic            s_readData_valid, s_readData_ready;
   logic [DW-1:0]   s_readData_bits_data;
   logic [1:0]      s_readData_bits_resp;
   logic            wr_busy, err_timeout;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .m_readAddr_valid(m_readAddr_valid), .m_readAddr_ready(m_readAddr_ready),
      .m_readAddr_bits_addr(m_readAddr_bits_addr),
      .m_readData_valid(m_readData_valid), .m_readData_ready(m_readData_ready),
      .m_readData_bits_data(m_readData_bits_data), .m_readData_bits_resp(m_readData_bits_resp),
      .s_readAddr_valid(s_readAddr_valid), .s_readAddr_ready(s_readAddr_ready),
      .s_readAddr_bits_addr(s_readAddr_bits_addr), .s_readAddr_bits_prot(s_readAddr_bits_prot),
      .s_readData_valid(s_readData_valid), .s_readData_ready(s_readData_ready),
      .s_readData_bits_data(s_readData_bits_data), .s_readData_bits_resp(s_readData_bits_resp),
      .wr_busy(wr_busy), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Memory contents as seen by the bench: each address returns a word derived from itself.
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return {~a, a};
   endfunction

   task automatic idle_inputs();
      m_readAddr_valid     = 2'b00;
      m_readAddr_bits_addr = '0;
      m_readData_ready     = 2'b00;
      s_readAddr_ready     = 1'b0;
      s_readData_valid     = 1'b0;
      s_readData_bits_data = '0;
      s_readData_bits_resp = 2'b00;
      wr_busy              = 1'b0;
   endtask

   task automatic pulse_reset();
      @(negedge clk); idle_inputs(); rst = 1'b0;
      @(negedge clk); rst = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      idle_inputs();
      m_readAddr_valid = 2'b11; m_readData_ready = 2'b11; s_readAddr_ready = 1'b1;
      s_readData_valid = 1'b1; s_readData_bits_data = '1; s_readData_bits_resp = 2'b11;
      @(negedge clk); @(negedge clk); #1;
      chk_cnt++; if ({m_readAddr_ready, m_readData_valid, s_readAddr_valid, s_readData_ready, err_timeout} !== 7'b0)
         $display("FAIL reset_ctrl: aready=%b dvalid=%b sav=%b sdr=%b err=%b required all 0", m_readAddr_ready, m_readData_valid, s_readAddr_valid, s_readData_ready, err_timeout);
      else pass_cnt++;
      chk_cnt++; if (m_readData_bits_data !== '0 || m_readData_bits_resp !== 2'b00)
         $display("FAIL reset_resp: data=%h resp=%b required 0", m_readData_bits_data, m_readData_bits_resp);
      else pass_cnt++;
      chk_cnt++; if (s_readAddr_bits_addr !== '0 || s_readAddr_bits_prot !== 3'b000)
         $display("FAIL reset_saddr: addr=%h prot=%b required 0", s_readAddr_bits_addr, s_readAddr_bits_prot);
      else pass_cnt++;
      @(negedge clk); idle_inputs(); rst = 1'b1;
   endtask

   task automatic test_single_m0();
      logic [DW-1:0] d;
      d = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
      @(negedge clk); idle_inputs();
      m_readAddr_valid = 2'b01; m_readAddr_bits_addr = {64'h0, 64'h8000_0000};
      s_readAddr_ready = 1'b1; m_readData_ready = 2'b01; #1;
      chk_cnt++; if (m_readAddr_ready !== 2'b01) $display("FAIL single_accept: ready=%b required 01", m_readAddr_ready); else pass_cnt++;
      @(negedge clk); m_readAddr_valid = 2'b00; #1;
      chk_cnt++; if (s_readAddr_valid !== 1'b1 || s_readAddr_bits_addr !== 64'h8000_0000 || s_readAddr_bits_prot !== 3'b100 || m_readAddr_ready !== 2'b00)
         $display("FAIL single_addr: valid=%b addr=%h prot=%b aready=%b required 1/80000000/100/00", s_readAddr_valid, s_readAddr_bits_addr, s_readAddr_bits_prot, m_readAddr_ready);
      else pass_cnt++;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk); #1;
         chk_cnt++; if (m_readData_valid !== 2'b00 || s_readAddr_valid !== 1'b0)
            $display("FAIL single_wait: dvalid=%b sav=%b required 00/0", m_readData_valid, s_readAddr_valid);
         else pass_cnt++;
      end
      @(negedge clk); s_readData_valid = 1'b1; s_readData_bits_data = d; #1;
      chk_cnt++; if (m_readData_valid !== 2'b01 || m_readData_bits_data !== d || m_readData_bits_resp !== 2'b00 || s_readData_ready !== 1'b1)
         $display("FAIL single_data: dvalid=%b data=%h resp=%b sdr=%b required 01/%h/00/1", m_readData_valid, m_readData_bits_data, m_readData_bits_resp, s_readData_ready, d);
      else pass_cnt++;
      @(negedge clk); idle_inputs(); #1;
      chk_cnt++; if (m_readData_valid !== 2'b00 || m_readData_bits_data !== '0 || s_readAddr_valid !== 1'b0)
         $display("FAIL single_after: dvalid=%b data=%h sav=%b required 00/0/0", m_readData_valid, m_readData_bits_data, s_readAddr_valid);
      else pass_cnt++;
      $display("txn single: m0 addr=80000000");
   endtask

   task automatic test_round_robin();
      pulse_reset();
      for (int i = 0; i < 4; i++) begin
         int e;
         logic [AW-1:0] a0, a1, ea;
         logic [1:0] exp_rdy;
         e = i % 2;
         a0 = 64'h1000 + 64'(i * 16);
         a1 = 64'h2000 + 64'(i * 16);
         ea = (e == 0) ? a0 : a1;
         exp_rdy = (e == 0) ? 2'b01 : 2'b10;
         @(negedge clk); idle_inputs();
         m_readAddr_valid = 2'b11; m_readAddr_bits_addr = {a1, a0};
         s_readAddr_ready = 1'b1; m_readData_ready = 2'b11; #1;
         chk_cnt++; if (m_readAddr_ready !== exp_rdy) $display("FAIL rr_grant%0d: ready=%b required %b", i, m_readAddr_ready, exp_rdy); else pass_cnt++;
         @(negedge clk); #1;
         chk_cnt++; if (s_readAddr_valid !== 1'b1 || s_readAddr_bits_addr !== ea || s_readAddr_bits_prot !== ((e == 0) ? 3'b100 : 3'b000) || m_readAddr_ready !== 2'b00)
            $display("FAIL rr_addr%0d: valid=%b addr=%h prot=%b aready=%b required 1/%h/m%0d", i, s_readAddr_valid, s_readAddr_bits_addr, s_readAddr_bits_prot, m_readAddr_ready, ea, e);
         else pass_cnt++;
         @(negedge clk); s_readData_valid = 1'b1; s_readData_bits_data = mem_word(ea); #1;
         chk_cnt++; if (m_readData_valid !== exp_rdy || m_readData_bits_data !== mem_word(ea))
            $display("FAIL rr_data%0d: dvalid=%b data=%h required %b/%h", i, m_readData_valid, m_readData_bits_data, exp_rdy, mem_word(ea));
         else pass_cnt++;
         $display("txn rr%0d: m%0d addr=%h", i, e, ea);
      end
   endtask

   task automatic test_wr_busy();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); idle_inputs();
         m_readAddr_valid = 2'b10; m_readAddr_bits_addr = {64'hDEAD_0000, 64'h0};
         wr_busy = 1'b1; s_readAddr_ready = 1'b1; #1;
         chk_cnt++; if (m_readAddr_ready !== 2'b00 || s_readAddr_valid !== 1'b0)
            $display("FAIL wrbusy_block%0d: ready=%b sav=%b required 00/0", k, m_readAddr_ready, s_readAddr_valid);
         else pass_cnt++;
      end
      @(negedge clk); wr_busy = 1'b0; #1;
      chk_cnt++; if (m_readAddr_ready !== 2'b10) $display("FAIL wrbusy_release: ready=%b required 10", m_readAddr_ready); else pass_cnt++;
      @(negedge clk); m_readAddr_valid = 2'b00; #1;
      chk_cnt++; if (s_readAddr_valid !== 1'b1 || s_readAddr_bits_prot !== 3'b000 || s_readAddr_bits_addr !== 64'hDEAD_0000)
         $display("FAIL wrbusy_addr: valid=%b prot=%b addr=%h required 1/000/dead0000", s_readAddr_valid, s_readAddr_bits_prot, s_readAddr_bits_addr);
      else pass_cnt++;
      @(negedge clk); s_readData_valid = 1'b1; s_readData_bits_data = mem_word(64'hDEAD_0000); m_readData_ready = 2'b10; #1;
      chk_cnt++; if (m_readData_valid !== 2'b10) $display("FAIL wrbusy_data: dvalid=%b required 10", m_readData_valid); else pass_cnt++;
      $display("txn wrbusy: m1 addr=dead0000");
   endtask

   task automatic test_resp_stall();
      logic [AW-1:0] a;
      a = 64'hCAFE_0040;
      @(negedge clk); idle_inputs();
      m_readAddr_valid = 2'b10; m_readAddr_bits_addr = {a, 64'h0}; s_readAddr_ready = 1'b1; #1;
      chk_cnt++; if (m_readAddr_ready !== 2'b10) $display("FAIL stall_accept: ready=%b required 10", m_readAddr_ready); else pass_cnt++;
      @(negedge clk); m_readAddr_valid = 2'b00;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); s_readData_valid = 1'b1; s_readData_bits_data = mem_word(a); m_readData_ready = 2'b00; #1;
         chk_cnt++; if (s_readData_ready !== 1'b0 || m_readData_valid !== 2'b10)
            $display("FAIL stall_hold%0d: sdr=%b dvalid=%b required 0/10", k, s_readData_ready, m_readData_valid);
         else pass_cnt++;
      end
      @(negedge clk); m_readData_ready = 2'b10; #1;
      chk_cnt++; if (s_readData_ready !== 1'b1 || m_readData_valid !== 2'b10)
         $display("FAIL stall_done: sdr=%b dvalid=%b required 1/10", s_readData_ready, m_readData_valid);
      else pass_cnt++;
      @(negedge clk); idle_inputs(); #1;
      chk_cnt++; if (m_readData_valid !== 2'b00 || err_timeout !== 1'b0 || s_readAddr_valid !== 1'b0)
         $display("FAIL stall_after: dvalid=%b err=%b sav=%b required 00/0/0", m_readData_valid, err_timeout, s_readAddr_valid);
      else pass_cnt++;
      $display("txn stall: m1 addr=%h", a);
   endtask

   task automatic test_timeout_boundary();
      logic [AW-1:0] a;
      a = 64'h4000_0100;
      @(negedge clk); idle_inputs();
      m_readAddr_valid = 2'b01; m_readAddr_bits_addr = {64'h0, a}; s_readAddr_ready = 1'b1;
      @(negedge clk); m_readAddr_valid = 2'b00;
      for (int k = 1; k < TO - 1; k++) begin
         @(negedge clk); m_readData_ready = 2'b01; #1;
         chk_cnt++; if (m_readData_valid !== 2'b00 || err_timeout !== 1'b0)
            $display("FAIL edge_wait%0d: dvalid=%b err=%b required 00/0", k, m_readData_valid, err_timeout);
         else pass_cnt++;
      end
      @(negedge clk); s_readData_valid = 1'b1; s_readData_bits_data = mem_word(a); s_readData_bits_resp = 2'b01; #1;
      chk_cnt++; if (m_readData_valid !== 2'b01 || m_readData_bits_resp !== 2'b01 || m_readData_bits_data !== mem_word(a))
         $display("FAIL edge_data: dvalid=%b resp=%b data=%h required 01/01/%h", m_readData_valid, m_readData_bits_resp, m_readData_bits_data, mem_word(a));
      else pass_cnt++;
      @(negedge clk); idle_inputs(); #1;
      chk_cnt++; if (err_timeout !== 1'b0 || m_readData_valid !== 2'b00)
         $display("FAIL edge_noerr: err=%b dvalid=%b required 0/00", err_timeout, m_readData_valid);
      else pass_cnt++;
      $display("txn edge: m0 addr=%h", a);
   endtask

   task automatic test_timeout();
      @(negedge clk); idle_inputs();
      m_readAddr_valid = 2'b01; m_readAddr_bits_addr = {64'h0, 64'h4000_0200}; s_readAddr_ready = 1'b1;
      s_readData_bits_data = '1; s_readData_bits_resp = 2'b11; #1;
      chk_cnt++; if (m_readAddr_ready !== 2'b01) $display("FAIL tmo_accept: ready=%b required 01", m_readAddr_ready); else pass_cnt++;
      for (int k = 0; k < TO; k++) begin
         @(negedge clk); m_readAddr_valid = 2'b00; #1;
         chk_cnt++; if (err_timeout !== 1'b0 || m_readData_valid !== 2'b00)
            $display("FAIL tmo_early%0d: err=%b dvalid=%b required 0/00", k, err_timeout, m_readData_valid);
         else pass_cnt++;
      end
      @(negedge clk); #1;
      chk_cnt++; if (err_timeout !== 1'b1) $display("FAIL tmo_flag: err=%b required 1", err_timeout); else pass_cnt++;
      chk_cnt++; if (m_readData_valid !== 2'b01 || m_readData_bits_data !== '0 || m_readData_bits_resp !== 2'b10)
         $display("FAIL tmo_resp: dvalid=%b data=%h resp=%b required 01/0/10", m_readData_valid, m_readData_bits_data, m_readData_bits_resp);
      else pass_cnt++;
      @(negedge clk); m_readData_ready = 2'b01; #1;
      chk_cnt++; if (s_readData_ready !== 1'b0 || s_readAddr_valid !== 1'b0 || m_readData_valid !== 2'b01)
         $display("FAIL tmo_err_hs: sdr=%b sav=%b dvalid=%b required 0/0/01", s_readData_ready, s_readAddr_valid, m_readData_valid);
      else pass_cnt++;
      @(negedge clk); idle_inputs(); m_readAddr_valid = 2'b11; #1;
      chk_cnt++; if (err_timeout !== 1'b1 || m_readData_valid !== 2'b00 || m_readAddr_ready !== 2'b10)
         $display("FAIL tmo_after: err=%b dvalid=%b ready=%b required 1/00/10", err_timeout, m_readData_valid, m_readAddr_ready);
      else pass_cnt++;
      @(negedge clk); idle_inputs();
      $display("txn timeout: m0 addr=40000200 resp=10");
   endtask

   // Transaction-level model: round-robin pick among waiting requesters, one read in flight.
   task automatic test_random();
      logic [1:0]    pend, exp_rdy, exp_dv;
      logic [AW-1:0] paddr [2];
      logic [AW-1:0] a_exp, mem_addr;
      bit            busy, mprio, g, mem_have, allow, done, exp_sav;
      int            mem_lat, addr_wait, stall, txns, w;
      pend = 2'b00; paddr[0] = '0; paddr[1] = '0; a_exp = '0; mem_addr = '0;
      busy = 0; mprio = 0; g = 0; mem_have = 0; done = 0;
      mem_lat = 0; addr_wait = 0; stall = 0; txns = 0;
      pulse_reset();
      for (int c = 0; c < 600 && !done; c++) begin
         allow = (c < 500);
         @(negedge clk);
         for (int r = 0; r < 2; r++)
            if (!pend[r] && allow && $urandom_range(0, 2) == 0) begin
               pend[r] = 1'b1;
               paddr[r] = {$urandom, $urandom};
            end
         m_readAddr_valid     = pend;
         m_readAddr_bits_addr = {paddr[1], paddr[0]};
         wr_busy              = ($urandom_range(0, 4) == 0);
         s_readAddr_ready     = (addr_wait > 0) || ($urandom_range(0, 1) == 1);
         s_readData_valid     = mem_have && (mem_lat == 0);
         s_readData_bits_data = mem_have ? mem_word(mem_addr) : {$urandom, $urandom, $urandom, $urandom};
         s_readData_bits_resp = mem_addr[1:0];
         m_readData_ready     = 2'($urandom_range(0, 3));
         if (stall > 0) m_readData_ready[g] = 1'b1;
         #1;
         exp_rdy = 2'b00; w = 0;
         if (!busy && !wr_busy && pend != 2'b00) begin
            w = pend[mprio] ? int'(mprio) : int'(!mprio);
            exp_rdy[w] = 1'b1;
         end
         chk_cnt++; if (m_readAddr_ready !== exp_rdy) $display("FAIL rnd_grant c%0d: ready=%b required %b", c, m_readAddr_ready, exp_rdy); else pass_cnt++;
         exp_sav = busy && !mem_have;
         chk_cnt++; if (s_readAddr_valid !== exp_sav || (exp_sav && (s_readAddr_bits_addr !== a_exp || s_readAddr_bits_prot !== {~g, 2'b00})))
            $display("FAIL rnd_addr c%0d: valid=%b addr=%h prot=%b required %b/%h/m%0d", c, s_readAddr_valid, s_readAddr_bits_addr, s_readAddr_bits_prot, exp_sav, a_exp, g);
         else pass_cnt++;
         exp_dv = 2'b00;
         if (busy && s_readData_valid) exp_dv[g] = 1'b1;
         chk_cnt++; if (m_readData_valid !== exp_dv || (exp_dv != 2'b00 && (m_readData_bits_data !== mem_word(a_exp) || m_readData_bits_resp !== a_exp[1:0]))
                        || (mem_have && s_readData_ready !== m_readData_ready[g]))
            $display("FAIL rnd_data c%0d: dvalid=%b data=%h resp=%b sdr=%b required %b/%h/%b", c, m_readData_valid, m_readData_bits_data, m_readData_bits_resp, s_readData_ready, exp_dv, mem_word(a_exp), a_exp[1:0]);
         else pass_cnt++;
         if (busy && s_readData_valid && m_readData_ready[g]) begin
            busy = 0; mem_have = 0; mprio = !g; stall = 0; txns++;
            $display("txn rnd%0d: m%0d addr=%h", txns, g, a_exp);
         end else if (s_readData_valid) stall++;
         if (busy && !mem_have && s_readAddr_valid && s_readAddr_ready) begin
            mem_have = 1; mem_addr = s_readAddr_bits_addr; mem_lat = int'($urandom_range(0, 1)); addr_wait = 0;
         end else if (busy && !mem_have) addr_wait++;
         else if (mem_have && mem_lat > 0) mem_lat--;
         if (exp_rdy != 2'b00) begin
            busy = 1; g = (w == 1); a_exp = paddr[w]; pend[w] = 1'b0; addr_wait = 0;
         end
         if (!allow && !busy && pend == 2'b00) done = 1;
      end
      chk_cnt++; if (!done || txns < 30) $display("FAIL rnd_drain: done=%0d txns=%0d required 1/>=30", done, txns); else pass_cnt++;
   endtask

   task automatic test_async_reset();
      logic [AW-1:0] a;
      a = 64'h5000_0000;
      @(negedge clk); idle_inputs();
      m_readAddr_valid = 2'b01; m_readAddr_bits_addr = {64'h0, a}; s_readAddr_ready = 1'b1; m_readData_ready = 2'b11;
      @(negedge clk); m_readAddr_valid = 2'b00;
      @(negedge clk); s_readData_valid = 1'b1; s_readData_bits_data = mem_word(a);
      @(negedge clk); idle_inputs();
      m_readAddr_valid = 2'b10; m_readAddr_bits_addr = {a, 64'h0}; s_readAddr_ready = 1'b1; #1;
      chk_cnt++; if (m_readAddr_ready !== 2'b10) $display("FAIL areset_pre_grant: ready=%b required 10", m_readAddr_ready); else pass_cnt++;
      @(negedge clk); m_readAddr_valid = 2'b00;
      @(negedge clk); m_readAddr_valid = 2'b11; m_readAddr_bits_addr = {a, a};
      s_readData_valid = 1'b1; s_readData_bits_data = mem_word(a); s_readData_bits_resp = 2'b01; #1;
      chk_cnt++; if (m_readData_valid !== 2'b10) $display("FAIL areset_pre_data: dvalid=%b required 10", m_readData_valid); else pass_cnt++;
      #2 rst = 1'b0;
      #1;
      chk_cnt++; if ({m_readAddr_ready, m_readData_valid, s_readAddr_valid, s_readData_ready, m_readData_bits_resp, s_readAddr_bits_prot} !== 11'b0
                     || m_readData_bits_data !== '0 || s_readAddr_bits_addr !== '0)
         $display("FAIL areset_outputs: aready=%b dvalid=%b sav=%b sdr=%b resp=%b data=%h required all 0", m_readAddr_ready, m_readData_valid, s_readAddr_valid, s_readData_ready, m_readData_bits_resp, m_readData_bits_data);
      else pass_cnt++;
      @(negedge clk); rst = 1'b1; s_readData_valid = 1'b0; #1;
      chk_cnt++; if (m_readAddr_ready !== 2'b01) $display("FAIL areset_first_grant: ready=%b required 01", m_readAddr_ready); else pass_cnt++;
      @(negedge clk); idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_single_m0();
      test_round_robin();
      test_wr_busy();
      test_resp_stall();
      test_timeout_boundary();
      test_timeout();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
